sudoku_move_ctrl: RTL and testbench

//  Parametrised user-move controller and win checker for an SIDE x SIDE sudoku

---
 rtl/sudoku_move_ctrl.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_sudoku_move_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_move_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_move_ctrl
//
// User-move controller and win checker for an SIDE x SIDE sudoku board.
// Row, column and value arrive one at a time on a narrow entry bus, each
// qualified by a rising edge of in_enter. The block owns the user board,
// refuses writes to given cells or out-of-range entries, and scans the whole
// board against the solution (one cell per cycle) after every accepted move.
//
// Parameters
//   SIDE   grid side length (4 or 9)
//   IDX_W  entry-bus / row / col index width, clog2(SIDE)
//   VAL_W  bits per cell, 0 encodes an empty cell
//
// Ports
//   in_clk        clock, all state on rising edge
//   in_restart_n  synchronous active-low reset
//   in_new_game   level, loads a new board from the generator (highest priority)
//   in_enter      entry strobe, rising edge detected internally
//   in_entry      row, col or value-1 depending on state
//   in_givens     1 = given cell, bit k = cell k = row*SIDE+col
//   in_solution   solved board, cell k at [k*VAL_W +: VAL_W]
//   out_board     current user board, same packing as in_solution
//   out_state     FSM state code (IDLE=0 LOAD=1 ROW=2 COL=3 VAL=4 CHECK=5 WIN=6)
//   out_reject    one-cycle pulse when an entry is refused
//   out_solved    high while in WIN
//   out_move_cnt  accepted-write count, saturating at 255
//                 (present only when SUDOKU_MOVE_CNT_EN is defined)
//
// Build option
//   SUDOKU_MOVE_CNT_EN  adds the move counter and the out_move_cnt port.
// -----------------------------------------------------------------------------
module sudoku_move_ctrl #(
    parameter int SIDE  = 4,
    parameter int IDX_W = 2,
    parameter int VAL_W = 3
) (
    input  logic                        in_clk,
    input  logic                        in_restart_n,
    input  logic                        in_new_game,
    input  logic                        in_enter,
    input  logic [IDX_W-1:0]            in_entry,
    input  logic [SIDE*SIDE-1:0]        in_givens,
    input  logic [SIDE*SIDE*VAL_W-1:0]  in_solution,
    output logic [SIDE*SIDE*VAL_W-1:0]  out_board,
    output logic [2:0]                  out_state,
    output logic                        out_reject,
`ifdef SUDOKU_MOVE_CNT_EN
    output logic                        out_solved,
    output logic [7:0]                  out_move_cnt
`else
    output logic                        out_solved
`endif
);

    localparam int CELLS  = SIDE * SIDE;
    localparam int CELL_W = $clog2(CELLS);
    // Wide enough to hold row*SIDE+col for any out-of-range row/col the bus can carry
    localparam int ADDR_W = 2 * IDX_W + 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROW   = 3'd2,
        S_COL   = 3'd3,
        S_VAL   = 3'd4,
        S_CHECK = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    // Registers
    state_t             r_state;
    logic [VAL_W-1:0]   r_cells [CELLS];
    logic               r_enter_q;
    logic [IDX_W-1:0]   r_row;
    logic [IDX_W-1:0]   r_col;
    logic [CELL_W-1:0]  r_idx;
    logic               r_reject;
    logic               r_solved;

    // Combinational signals
    state_t             w_next_state;
    logic               w_enter_edge;
    logic [ADDR_W-1:0]  w_row_ext;
    logic [ADDR_W-1:0]  w_col_ext;
    logic [ADDR_W-1:0]  w_entry_ext;
    logic [ADDR_W-1:0]  w_addr;
    logic [CELL_W-1:0]  w_cell_idx;
    logic               w_in_range;
    logic               w_val_bad;
    logic               w_given_hit;
    logic               w_move_bad;
    logic [VAL_W-1:0]   w_val;
    logic [VAL_W-1:0]   w_sol [CELLS];
    logic               w_idx_match;
    logic               w_idx_last;
    logic               w_load;
    logic               w_row_we;
    logic               w_col_we;
    logic               w_write;
    logic               w_rej;
    logic               w_idx_inc;

    assign w_enter_edge = in_enter & ~r_enter_q;

    // Entry decode: cell address, range checks and the value to be written
    always_comb begin
        w_row_ext   = {{(ADDR_W-IDX_W){1'b0}}, r_row};
        w_col_ext   = {{(ADDR_W-IDX_W){1'b0}}, r_col};
        w_entry_ext = {{(ADDR_W-IDX_W){1'b0}}, in_entry};
        w_addr      = (w_row_ext * ADDR_W'(SIDE)) + w_col_ext;
        w_cell_idx  = w_addr[CELL_W-1:0];
        w_in_range  = (w_row_ext < ADDR_W'(SIDE)) && (w_col_ext < ADDR_W'(SIDE))
                      && (w_addr < ADDR_W'(CELLS));
        // value = entry+1 exceeds SIDE exactly when entry >= SIDE; compared
        // wide so an all-ones entry cannot wrap into a bogus empty cell
        w_val_bad   = (w_entry_ext >= ADDR_W'(SIDE));
        w_val       = w_entry_ext[VAL_W-1:0] + {{(VAL_W-1){1'b0}}, 1'b1};
        if (w_in_range) begin
            w_given_hit = in_givens[w_cell_idx];
        end else begin
            w_given_hit = 1'b0;
        end
        w_move_bad  = ~w_in_range | w_val_bad | w_given_hit;
    end

    // Unpack the solution bus into per-cell values
    always_comb begin
        for (int k = 0; k < CELLS; k++) begin
            w_sol[k] = in_solution[k*VAL_W +: VAL_W];
        end
    end

    // Scan comparison for the cell currently addressed by the check index
    always_comb begin
        w_idx_match = (r_cells[r_idx] == w_sol[r_idx]);
        w_idx_last  = (r_idx == CELL_W'(CELLS - 1));
    end

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_row_we     = 1'b0;
        w_col_we     = 1'b0;
        w_write      = 1'b0;
        w_rej        = 1'b0;
        w_idx_inc    = 1'b0;
        if (in_new_game) begin
            // A new game wins over any enter edge arriving in the same cycle
            w_next_state = S_LOAD;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_next_state = S_IDLE;
                end
                S_LOAD: begin
                    w_load       = 1'b1;
                    w_next_state = S_ROW;
                end
                S_ROW: begin
                    if (w_enter_edge) begin
                        w_row_we     = 1'b1;
                        w_next_state = S_COL;
                    end else begin
                        w_next_state = S_ROW;
                    end
                end
                S_COL: begin
                    if (w_enter_edge) begin
                        w_col_we     = 1'b1;
                        w_next_state = S_VAL;
                    end else begin
                        w_next_state = S_COL;
                    end
                end
                S_VAL: begin
                    if (w_enter_edge) begin
                        if (w_move_bad) begin
                            w_rej        = 1'b1;
                            w_next_state = S_ROW;
                        end else begin
                            w_write      = 1'b1;
                            w_next_state = S_CHECK;
                        end
                    end else begin
                        w_next_state = S_VAL;
                    end
                end
                S_CHECK: begin
                    // Early abort on the first mismatching cell
                    if (!w_idx_match) begin
                        w_next_state = S_ROW;
                    end else if (w_idx_last) begin
                        w_next_state = S_WIN;
                    end else begin
                        w_idx_inc    = 1'b1;
                        w_next_state = S_CHECK;
                    end
                end
                S_WIN: begin
                    w_next_state = S_WIN;
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end
    end

    // FSM state register and registered status outputs
    always_ff @(posedge in_clk) begin
        if (!in_restart_n) begin
            r_state   <= S_IDLE;
            r_enter_q <= 1'b0;
            r_reject  <= 1'b0;
            r_solved  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_enter_q <= in_enter;
            r_reject  <= w_rej;
            r_solved  <= (w_next_state == S_WIN);
        end
    end

    // Board, pending row/col and scan index
    always_ff @(posedge in_clk) begin
        if (!in_restart_n) begin
            for (int k = 0; k < CELLS; k++) begin
                r_cells[k] <= {VAL_W{1'b0}};
            end
            r_row <= {IDX_W{1'b0}};
            r_col <= {IDX_W{1'b0}};
            r_idx <= {CELL_W{1'b0}};
        end else if (w_load) begin
            for (int k = 0; k < CELLS; k++) begin
                r_cells[k] <= in_givens[k] ? w_sol[k] : {VAL_W{1'b0}};
            end
            r_row <= {IDX_W{1'b0}};
            r_col <= {IDX_W{1'b0}};
            r_idx <= {CELL_W{1'b0}};
        end else begin
            if (w_row_we) begin
                r_row <= in_entry;
            end else begin
                r_row <= r_row;
            end
            if (w_col_we) begin
                r_col <= in_entry;
            end else begin
                r_col <= r_col;
            end
            if (w_write) begin
                r_cells[w_cell_idx] <= w_val;
                r_idx               <= {CELL_W{1'b0}};
            end else if (w_idx_inc) begin
                r_idx <= r_idx + {{(CELL_W-1){1'b0}}, 1'b1};
            end else begin
                r_idx <= r_idx;
            end
        end
    end

`ifdef SUDOKU_MOVE_CNT_EN
    logic [7:0] r_move_cnt;

    // Accepted-write counter, saturating at 255
    always_ff @(posedge in_clk) begin
        if (!in_restart_n) begin
            r_move_cnt <= 8'd0;
        end else if (w_load) begin
            r_move_cnt <= 8'd0;
        end else if (w_write && (r_move_cnt != 8'hFF)) begin
            r_move_cnt <= r_move_cnt + 8'd1;
        end else begin
            r_move_cnt <= r_move_cnt;
        end
    end

    assign out_move_cnt = r_move_cnt;
`endif

    // Repack the registered board onto the output bus
    always_comb begin
        out_board = {(CELLS*VAL_W){1'b0}};
        for (int k = 0; k < CELLS; k++) begin
            out_board[k*VAL_W +: VAL_W] = r_cells[k];
        end
    end

    assign out_state  = r_state;
    assign out_reject = r_reject;
    assign out_solved = r_solved;

endmodule

// File: tb/tb_sudoku_move_ctrl.sv
module tb_sudoku_move_ctrl;

    localparam int SIDE  = 4;
    localparam int IDX_W = 2;
    localparam int VAL_W = 3;
    localparam int CELLS = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_ROW   = 3'd2;
    localparam logic [2:0] ST_COL   = 3'd3;
    localparam logic [2:0] ST_VAL   = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_WIN   = 3'd6;

    logic                       clk = 1'b0;
    logic                       restart_n;
    logic                       new_game;
    logic                       enter;
    logic [IDX_W-1:0]           entry;
    logic [CELLS-1:0]           givens;
    logic [CELLS*VAL_W-1:0]     solution;
    logic [CELLS*VAL_W-1:0]     board;
    logic [2:0]                 state;
    logic                       reject;
    logic                       solved;
`ifdef SUDOKU_MOVE_CNT_EN
    logic [7:0]                 move_cnt;
`endif

    int errors = 0;
    int checks = 0;

    int sol_v [CELLS] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
    int exp_cells [CELLS];

    typedef struct {
        bit         rst_n;
        bit         ng;
        bit         en;
        logic [1:0] ent;
        logic [2:0] exp_st;
        bit         exp_rej;
        bit         exp_sol;
    } vec_t;

    vec_t vecs [12];

    sudoku_move_ctrl #(.SIDE(SIDE), .IDX_W(IDX_W), .VAL_W(VAL_W)) dut (
        .in_clk       (clk),
        .in_restart_n (restart_n),
        .in_new_game  (new_game),
        .in_enter     (enter),
        .in_entry     (entry),
        .in_givens    (givens),
        .in_solution  (solution),
        .out_board    (board),
        .out_state    (state),
        .out_reject   (reject),
`ifdef SUDOKU_MOVE_CNT_EN
        .out_solved   (solved),
        .out_move_cnt (move_cnt)
`else
        .out_solved   (solved)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CELLS*VAL_W-1:0] model_board();
        logic [CELLS*VAL_W-1:0] b;
        b = '0;
        for (int k = 0; k < CELLS; k++) begin
            b[k*VAL_W +: VAL_W] = 3'(exp_cells[k]);
        end
        return b;
    endfunction

    task automatic model_load();
        for (int k = 0; k < CELLS; k++) begin
            exp_cells[k] = givens[k] ? sol_v[k] : 0;
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < CELLS; k++) begin
            exp_cells[k] = 0;
        end
    endtask

    task automatic pulse(input int v);
        entry = 2'(v);
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic new_game_seq();
        new_game = 1'b1;
        tick();
        chk("ng_load_state", 64'(state), 64'(ST_LOAD));
        new_game = 1'b0;
        tick();
        chk("ng_row_state", 64'(state), 64'(ST_ROW));
        model_load();
        chk("ng_board", 64'(board), 64'(model_board()));
    endtask

    // Accepted move: exp_n = hand-computed number of cycles spent in CHECK
    task automatic do_move(input int r, input int c, input int v, input int exp_n, input bit exp_win);
        int n;
        pulse(r);
        chk("mv_col_state", 64'(state), 64'(ST_COL));
        tick();
        pulse(c);
        chk("mv_val_state", 64'(state), 64'(ST_VAL));
        tick();
        pulse(v - 1);
        chk("mv_check_state", 64'(state), 64'(ST_CHECK));
        chk("mv_no_reject", 64'(reject), 64'd0);
        exp_cells[r*SIDE + c] = v;
        n = 0;
        while (state == ST_CHECK && n < 40) begin
            n++;
            // an enter edge during the scan must be ignored
            enter = (n == 3);
            entry = 2'd1;
            tick();
        end
        enter = 1'b0;
        chk("mv_check_cycles", 64'(n), 64'(exp_n));
        chk("mv_end_state", 64'(state), exp_win ? 64'(ST_WIN) : 64'(ST_ROW));
        chk("mv_solved", 64'(solved), 64'(exp_win));
        chk("mv_board", 64'(board), 64'(model_board()));
    endtask

    task automatic reject_move(input int r, input int c, input int v);
        pulse(r);
        tick();
        pulse(c);
        tick();
        pulse(v - 1);
        chk("rj_state", 64'(state), 64'(ST_ROW));
        chk("rj_pulse", 64'(reject), 64'd1);
        tick();
        chk("rj_pulse_end", 64'(reject), 64'd0);
        chk("rj_board", 64'(board), 64'(model_board()));
    endtask

    initial begin
        restart_n = 1'b0;
        new_game  = 1'b0;
        enter     = 1'b0;
        entry     = 2'd0;
        givens    = 16'h00FF;
        solution  = '0;
        for (int k = 0; k < CELLS; k++) begin
            solution[k*VAL_W +: VAL_W] = 3'(sol_v[k]);
        end

        // rst ng en entry -> state rej sol
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, ST_IDLE, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, ST_IDLE, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, ST_IDLE, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, ST_LOAD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, ST_ROW,  1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, ST_COL,  1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'd0, ST_COL,  1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, ST_COL,  1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, ST_VAL,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'd0, ST_VAL,  1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 2'd2, ST_ROW,  1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, ST_ROW,  1'b0, 1'b0};

        // Reset, load and a refused write to given cell 0
        for (int i = 0; i < 12; i++) begin
            restart_n = vecs[i].rst_n;
            new_game  = vecs[i].ng;
            enter     = vecs[i].en;
            entry     = vecs[i].ent;
            tick();
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp_st));
            chk($sformatf("vec%0d_reject", i), 64'(reject), 64'(vecs[i].exp_rej));
            chk($sformatf("vec%0d_solved", i), 64'(solved), 64'(vecs[i].exp_sol));
            if (i == 0) begin
                chk("reset_board", 64'(board), 64'd0);
            end
        end
        enter = 1'b0;
        model_load();
        chk("load_board", 64'(board), 64'(model_board()));

        // Fill cells 8..15 in order; each scan aborts at the next empty cell
        for (int k = 8; k < 16; k++) begin
            do_move(k / 4, k % 4, sol_v[k], (k == 15) ? 16 : k + 2, k == 15);
        end
`ifdef SUDOKU_MOVE_CNT_EN
        chk("cnt_after_fill", 64'(move_cnt), 64'd8);
`endif

        // Enters in WIN leave everything frozen
        for (int i = 0; i < 3; i++) begin
            pulse(i);
            tick();
            chk("win_hold_state", 64'(state), 64'(ST_WIN));
            chk("win_hold_solved", 64'(solved), 64'd1);
            chk("win_hold_board", 64'(board), 64'(model_board()));
        end

        // New game and enter edge together in WIN: new game wins
        new_game = 1'b1;
        entry    = 2'd1;
        enter    = 1'b1;
        tick();
        chk("win_ng_state", 64'(state), 64'(ST_LOAD));
        chk("win_ng_solved", 64'(solved), 64'd0);
        new_game = 1'b0;
        enter    = 1'b0;
        tick();
        chk("win_ng_row", 64'(state), 64'(ST_ROW));
        model_load();
        chk("win_ng_board", 64'(board), 64'(model_board()));
`ifdef SUDOKU_MOVE_CNT_EN
        chk("cnt_after_load", 64'(move_cnt), 64'd0);
`endif

        // Refused write to given cell 5, then cells 9..15 with cell 8 empty
        reject_move(1, 1, 4);
        for (int k = 9; k < 16; k++) begin
            do_move(k / 4, k % 4, sol_v[k], 9, 1'b0);
        end
        do_move(2, 0, 3, 9, 1'b0);
        do_move(2, 0, 2, 16, 1'b1);
`ifdef SUDOKU_MOVE_CNT_EN
        chk("cnt_after_seq", 64'(move_cnt), 64'd9);
`endif

        // Reset in the middle of a CHECK scan
        new_game_seq();
        pulse(3);
        tick();
        pulse(3);
        tick();
        pulse(0);
        chk("rst_mid_check", 64'(state), 64'(ST_CHECK));
        tick();
        restart_n = 1'b0;
        tick();
        restart_n = 1'b1;
        model_clear();
        chk("rst_mid_state", 64'(state), 64'(ST_IDLE));
        chk("rst_mid_board", 64'(board), 64'(model_board()));
        chk("rst_mid_solved", 64'(solved), 64'd0);
        tick();
        chk("rst_mid_idle", 64'(state), 64'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
